// File: rtl/alu_pkg.sv
// Shared types for the sequential execute-stage ALU:
// op encodings, FSM states and op-class helpers.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } alu_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= 5'd10) && (op <= 5'd17);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= 5'd14) && (op <= 5'd17);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Serial magnitude datapath: shift-add multiply or
// restoring divide, one bit per clock, XLEN iterations.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              div,
  input  logic [XLEN-1:0]   ma,
  input  logic [XLEN-1:0]   mb,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] acc_next
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt;
  logic              mode;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN:0]     part;
  logic [XLEN-1:0]   diff;
  logic              ge;

  assign busy = cnt != '0;
  assign done = cnt == CW'(1);

  // Divide keeps {remainder, dividend/quotient} in acc
  always_comb begin
    part = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge   = part >= {1'b0, mplier};
    diff = part[XLEN-1:0] - mplier;
    if (mode) begin
      acc_next = {ge ? diff : part[XLEN-1:0],
                  acc[XLEN-2:0], ge};
    end else if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CW'(XLEN);
      mode   <= div;
      acc    <= div ? {{XLEN{1'b0}}, ma} : '0;
      mcand  <= {{XLEN{1'b0}}, ma};
      mplier <= mb;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      acc <= acc_next;
      if (!mode) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle base ops,
// iterative RV32M mul/div, valid/ready on both sides.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e state, state_n, launch_st;

  logic              accept, start, div_op;
  logic              go_iter, b_zero, ovf;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic              neg_n, neg_q;
  logic              it_busy, it_done;
  logic [4:0]        op_q;
  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   ma, mb, quick, fin;
  logic [XLEN-1:0]   q_mag, r_mag;
  logic [2*XLEN-1:0] acc_next, prod;

  assign in_ready  = (state == ST_IDLE) ||
                     (state == ST_DONE && out_ready);
  assign out_valid = state == ST_DONE;
  assign accept    = in_valid && in_ready;
  assign div_op    = is_div(op);
  assign shamt     = b[SW-1:0];
  assign b_zero    = b == '0;
  assign ovf       = (op == OP_DIV || op == OP_REM) &&
                     a == MIN && b == '1;
  assign go_iter   = is_muldiv(op) &&
                     !(div_op && (b_zero || ovf));
  assign start     = accept && go_iter;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      (op == OP_MUL || op == OP_MULH ||
       op == OP_DIV || op == OP_REM): begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      (op == OP_MULHSU): a_sgn = 1'b1;
      default: ;
    endcase
  end

  // Remainder follows the dividend; everything else is sign xor
  assign a_neg = a_sgn && a[XLEN-1];
  assign b_neg = b_sgn && b[XLEN-1];
  assign ma    = a_neg ? -a : a;
  assign mb    = b_neg ? -b : b;
  assign neg_n = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    quick = '0;
    case (op)
      OP_ADD:  quick = a + b;
      OP_SUB:  quick = a - b;
      OP_AND:  quick = a & b;
      OP_OR:   quick = a | b;
      OP_XOR:  quick = a ^ b;
      OP_SLT:  quick = {{(XLEN-1){1'b0}},
                        $signed(a) < $signed(b)};
      OP_SLTU: quick = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:  quick = a << shamt;
      OP_SRL:  quick = a >> shamt;
      OP_SRA:  quick = $signed(a) >>> shamt;
      OP_DIV:  quick = b_zero ? '1 : MIN;
      OP_DIVU: quick = '1;
      OP_REM:  quick = b_zero ? a : '0;
      OP_REMU: quick = a;
      default: quick = '0;
    endcase
  end

  always_comb begin
    prod  = neg_q ? -acc_next : acc_next;
    q_mag = acc_next[XLEN-1:0];
    r_mag = acc_next[2*XLEN-1:XLEN];
    fin   = '0;
    case (op_q)
      OP_MUL:    fin = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  fin = prod[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU:   fin = neg_q ? -q_mag : q_mag;
      OP_REM,
      OP_REMU:   fin = neg_q ? -r_mag : r_mag;
      default:   fin = '0;
    endcase
  end

  always_comb begin
    launch_st = ST_DONE;
    if (go_iter) launch_st = div_op ? ST_DIV : ST_MUL;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (accept) state_n = launch_st;
      ST_MUL,
      ST_DIV: begin
        if (it_done || !it_busy) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready)
          state_n = accept ? launch_st : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      zero   <= 1'b0;
      op_q   <= '0;
      neg_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= op;
        neg_q <= neg_n;
      end
      if (accept && !go_iter) begin
        result <= quick;
        zero   <= quick == '0;
      end else if ((state == ST_MUL || state == ST_DIV)
                   && it_done) begin
        result <= fin;
        zero   <= fin == '0;
      end
    end
  end

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .div      (div_op),
    .ma       (ma),
    .mb       (mb),
    .busy     (it_busy),
    .done     (it_done),
    .acc_next (acc_next)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with an arithmetic reference
// model and a per-cycle scoreboard compare.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;
  bit   late = 1'b0;

  seq_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] model(
    input logic [4:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [63:0] p;
    longint      sx, sy, uy;
    logic        ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'd6:  return (x < y) ? 32'd1 : 32'd0;
      5'd7:  return x << y[4:0];
      5'd8:  return x >> y[4:0];
      5'd9:  return 32'($signed(x) >>> y[4:0]);
      5'd10: begin p = 64'(sx * sy); return p[31:0]; end
      5'd11: begin p = 64'(sx * sy); return p[63:32]; end
      5'd12: begin p = 64'(sx * uy); return p[63:32]; end
      5'd13: begin
        p = {32'd0, x} * {32'd0, y};
        return p[63:32];
      end
      5'd14: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ov) return x;
        return 32'(sx / sy);
      end
      5'd15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd16: begin
        if (y == 0) return x;
        if (ov) return 32'd0;
        return 32'(sx % sy);
      end
      5'd17: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat(
    input logic [4:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic ov;
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (o >= 10 && o <= 13) return 33;
    if (o >= 14 && o <= 17) begin
      if (y == 0) return 1;
      if ((o == 14 || o == 16) && ov) return 1;
      return 33;
    end
    return 1;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @cyc %0d",
               name, got, exp, cyc);
    end
  endtask

  // Scoreboard: check head entry while out_valid, pop on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc, sb[0].due);
          end
          chk("result", result, sb[0].res);
          chk("zero", {31'd0, zero},
              {31'd0, sb[0].res == 32'd0});
          if (!out_ready)
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            late = 1'b0;
          end
        end
      end else if (sb.size() > 0 && !late &&
                   cyc > sb[0].due) begin
        late = 1'b1;
        chk("late_valid", {31'd0, out_valid}, 32'd1);
      end
      if (in_valid && in_ready)
        sb.push_back('{model(op, a, b),
                       cyc + lat(op, a, b)});
    end
  end

  task automatic send(
    input logic [4:0] o,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] lit
  );
    bit got;
    chk("model_pin", model(o, x, y), lit);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // back-to-back simple ops, one per cycle
    send(5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    send(5'd5, 32'h8000_0000, 32'd1, 32'd1);
    send(5'd6, 32'h8000_0000, 32'd1, 32'd0);
    send(5'd9, 32'h8000_0000, 32'h21, 32'hC000_0000);
    send(5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    send(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    send(5'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    send(5'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA);
    send(5'd7, 32'h0000_0003, 32'h24, 32'h0000_0030);
    send(5'd8, 32'h8000_0000, 32'd31, 32'd1);
    send(5'd20, 32'd9, 32'd9, 32'd0);
    drain();

    send(5'd10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    drain();
    send(5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    drain();
    send(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    drain();
    send(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    send(5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    drain();
    send(5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    drain();
    send(5'd15, 32'd100, 32'd7, 32'd14);
    drain();
    send(5'd17, 32'd100, 32'd7, 32'd2);
    drain();

    send(5'd14, 32'd5, 32'd0, 32'hFFFF_FFFF);
    send(5'd17, 32'd5, 32'd0, 32'd5);
    send(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    drain();

    // backpressure, then release together with a new ADD
    out_ready = 1'b0;
    send(5'd10, 32'd6, 32'd7, 32'd42);
    begin
      bit vis;
      vis = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (out_valid) begin
          vis = 1'b1;
          break;
        end
      end
      if (!vis) chk("bp_valid_timeout", 32'd0, 32'd1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    chk("model_pin", model(5'd0, 32'd10, 32'd20), 32'd30);
    out_ready = 1'b1;
    op = 5'd0;
    a = 32'd10;
    b = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    drain();

    // asynchronous reset in the middle of a divide
    send(5'd15, 32'd1000, 32'd3, 32'd333);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    sb.delete();
    seen = 1'b0;
    late = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(5'd0, 32'd2, 32'd3, 32'd5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
